vend_dispenser: RTL and testbench

VEND_DISPENSER -- requirements
Module: vend_dispenser

---
 rtl/vend_dispenser.sv | 178 +++++++++++++++++
 tb/tb_vend_dispenser.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser.sv
// Vending dispenser: releases a latched item code, then pays change as 10-unit coins
// over ready/valid handshakes. Define VEND_DISPENSER_QUEUE_EN for a 2-entry event FIFO.
module vend_dispenser #(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] item,
   input  logic [1:0] change,
   output logic       item_valid,
   output logic [1:0] item_code,
   input  logic       item_ready,
   output logic       coin_valid,
   input  logic       coin_ready,
   output logic       busy,
   output logic       drop_err,
   output logic [7:0] coin_total
);

   typedef enum logic [1:0] {IDLE, ITEM, COIN, GAP} state_t;

   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [1:0] code_q;
   logic [2:0] cnt_q;
   logic [3:0] gap_q;
   logic [7:0] total_q;
   logic       drop_q;

   logic       ev;
   logic [1:0] ev_code;
   logic [2:0] ev_cnt;
   logic       st_go;
   logic [1:0] st_code;
   logic [2:0] st_cnt;
   logic       drop;
   logic       coin_xfer;

   always_comb begin
      ev_code = '0;
      if (item == 2'b01 || item == 2'b10) ev_code = item;
      case (change)
         2'b00:   ev_cnt = 3'd0;
         2'b01:   ev_cnt = 3'd1;
         2'b10:   ev_cnt = 3'd3;
         default: ev_cnt = 3'd4;
      endcase
      ev = (ev_code != 2'b00) || (change != 2'b00);
   end

`ifdef VEND_DISPENSER_QUEUE_EN
   logic [4:0] fq0, fq1;
   logic [1:0] fcnt;
   logic       pop, push_req, push_ok;
   logic [4:0] ev_ent;

   // The FIFO head is served only from IDLE; a simultaneous input event goes behind it.
   always_comb begin
      ev_ent   = {ev_code, ev_cnt};
      pop      = (state_q == IDLE) && (fcnt != 2'd0);
      push_req = ev && ((state_q != IDLE) || (fcnt != 2'd0));
      push_ok  = push_req && ((fcnt != 2'd2) || pop);
      drop     = push_req && !push_ok;
      st_go    = pop || ((state_q == IDLE) && ev);
      st_code  = pop ? fq0[4:3] : ev_code;
      st_cnt   = pop ? fq0[2:0] : ev_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq0  <= '0;
         fq1  <= '0;
         fcnt <= '0;
      end else begin
         case ({push_ok, pop})
            2'b10: begin
               if (fcnt == 2'd0) fq0 <= ev_ent;
               else              fq1 <= ev_ent;
               fcnt <= fcnt + 2'd1;
            end
            2'b01: begin
               fq0  <= fq1;
               fcnt <= fcnt - 2'd1;
            end
            2'b11: begin
               if (fcnt == 2'd1) begin
                  fq0 <= ev_ent;
               end else begin
                  fq0 <= fq1;
                  fq1 <= ev_ent;
               end
            end
            default: ;
         endcase
      end
   end
`else
   always_comb begin
      drop    = ev && (state_q != IDLE);
      st_go   = (state_q == IDLE) && ev;
      st_code = ev_code;
      st_cnt  = ev_cnt;
   end
`endif

   assign coin_xfer = (state_q == COIN) && coin_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (st_go) begin
               if (st_code != 2'b00)    state_d = ITEM;
               else if (st_cnt != 3'd0) state_d = COIN;
            end
         end
         ITEM: begin
            if (item_ready) state_d = (cnt_q != 3'd0) ? COIN : IDLE;
         end
         COIN: begin
            if (coin_ready) begin
               if (cnt_q > 3'd1) state_d = (GAP_CYCLES > 0) ? GAP : COIN;
               else              state_d = IDLE;
            end
         end
         GAP: begin
            if (gap_q == 4'd0) state_d = COIN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q  <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         total_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         if (st_go) begin
            code_q <= st_code;
            cnt_q  <= st_cnt;
         end else if (coin_xfer) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (coin_xfer) begin
            total_q <= total_q + 8'd1;
            gap_q   <= GAP_LOAD;
         end else if (state_q == GAP && gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
         end
         if (drop) drop_q <= 1'b1;
      end
   end

   always_comb begin
      item_valid = 1'b0;
      coin_valid = 1'b0;
      busy       = 1'b0;
      case (state_q)
         ITEM:    begin item_valid = 1'b1; busy = 1'b1; end
         COIN:    begin coin_valid = 1'b1; busy = 1'b1; end
         GAP:     busy = 1'b1;
         default: ;
      endcase
      item_code  = code_q;
      drop_err   = drop_q;
      coin_total = total_q;
   end

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: two instances (GAP_CYCLES 0 and 2) share directed and random
// stimulus and are compared every cycle against a transaction-list reference model.
module tb_vend_dispenser;

   localparam int COINS = 8;
   localparam int GAPS  = 9;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] item, change;
   logic       item_ready, coin_ready;

   logic       iv0, cv0, b0, de0, iv2, cv2, b2, de2;
   logic [1:0] ic0, ic2;
   logic [7:0] ct0, ct2;

   int checks = 0;
   int errors = 0;

   int       lst  [2][$];
   int       pend [2][$];
   bit       drop [2];
   bit [7:0] tot  [2];
   int       gapn [2] = '{0, 2};
   int       cmap [4] = '{0, 1, 3, 4};

   always #5 clk = ~clk;

   vend_dispenser #(.GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .item(item), .change(change),
      .item_valid(iv0), .item_code(ic0), .item_ready(item_ready),
      .coin_valid(cv0), .coin_ready(coin_ready), .busy(b0),
      .drop_err(de0), .coin_total(ct0)
   );

   vend_dispenser #(.GAP_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .item(item), .change(change),
      .item_valid(iv2), .item_code(ic2), .item_ready(item_ready),
      .coin_valid(cv2), .coin_ready(coin_ready), .busy(b2),
      .drop_err(de2), .coin_total(ct2)
   );

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         lst[d].delete();
         pend[d].delete();
         drop[d] = 1'b0;
         tot[d]  = 8'd0;
      end
   endtask

   task automatic build(int d, int code, int n);
      if (code != 0) lst[d].push_back(code);
      for (int k = 0; k < n; k++) begin
         if (k > 0) for (int g = 0; g < gapn[d]; g++) lst[d].push_back(GAPS);
         lst[d].push_back(COINS);
      end
   endtask

   task automatic model_edge(int d);
      int  code, n, h, p;
      bit  ev;
      code = (item == 2'b01 || item == 2'b10) ? int'(item) : 0;
      n    = cmap[change];
      ev   = (code != 0) || (n != 0);
      if (lst[d].size() != 0) begin
         h = lst[d][0];
         if ((h == 1 || h == 2) && item_ready) begin
            void'(lst[d].pop_front());
         end else if (h == COINS && coin_ready) begin
            void'(lst[d].pop_front());
            tot[d] = tot[d] + 8'd1;
         end else if (h == GAPS) begin
            void'(lst[d].pop_front());
         end
         if (ev) begin
`ifdef VEND_DISPENSER_QUEUE_EN
            if (pend[d].size() < 2) pend[d].push_back(code * 8 + n);
            else drop[d] = 1'b1;
`else
            drop[d] = 1'b1;
`endif
         end
      end else if (pend[d].size() != 0) begin
         p = pend[d].pop_front();
         build(d, p / 8, p % 8);
         if (ev) pend[d].push_back(code * 8 + n);
      end else if (ev) begin
         build(d, code, n);
      end
   endtask

   task automatic chk_dut(string tg, int d, logic iv, logic [1:0] ic, logic cv,
                          logic b, logic de, logic [7:0] ct);
      bit exp_iv, exp_cv;
      int h;
      h      = (lst[d].size() != 0) ? lst[d][0] : 0;
      exp_iv = (h == 1 || h == 2);
      exp_cv = (h == COINS);
      chk({tg, ".item_valid"}, {7'd0, iv}, {7'd0, exp_iv});
      chk({tg, ".coin_valid"}, {7'd0, cv}, {7'd0, exp_cv});
      chk({tg, ".busy"}, {7'd0, b}, {7'd0, lst[d].size() != 0});
      chk({tg, ".drop_err"}, {7'd0, de}, {7'd0, drop[d]});
      chk({tg, ".coin_total"}, ct, tot[d]);
      chk({tg, ".valid_excl"}, {7'd0, iv & cv}, 8'd0);
      if (exp_iv) chk({tg, ".item_code"}, {6'd0, ic}, 8'(h));
   endtask

   task automatic compare_all();
      chk_dut("g0", 0, iv0, ic0, cv0, b0, de0, ct0);
      chk_dut("g2", 1, iv2, ic2, cv2, b2, de2, ct2);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         model_edge(0);
         model_edge(1);
      end
      #1;
      compare_all();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      item = 2'b00; change = 2'b00; item_ready = 1'b0; coin_ready = 1'b0;
      model_reset();
      #12 compare_all();
      chk("reset.item_code", {6'd0, ic0}, 8'd0);
      tick();
      rst_n = 1'b1;
      ticks(2);

      // single twenty-item, no change
      item_ready = 1'b1; coin_ready = 1'b1;
      item = 2'b01; change = 2'b00;
      tick();
      chk("s1.item_valid", {7'd0, iv0}, 8'd1);
      chk("s1.item_code", {6'd0, ic0}, 8'd1);
      item = 2'b00;
      ticks(3);
      chk("s1.coin_total", ct0, 8'd0);

      // fifty-item with 4 coins, both ready
      item = 2'b10; change = 2'b11;
      tick();
      item = 2'b00; change = 2'b00;
      ticks(8);
      chk("s2.coin_total", ct0, 8'd4);

      // item with 3 coins, hopper stalls for 5 cycles
      item_ready = 1'b1; coin_ready = 1'b0;
      item = 2'b01; change = 2'b10;
      tick();
      item = 2'b00; change = 2'b00;
      ticks(6);
      coin_ready = 1'b1;
      ticks(12);

      // second event two cycles into a busy transaction
      item_ready = 1'b0; coin_ready = 1'b0;
      item = 2'b01; change = 2'b01;
      tick();
      item = 2'b00; change = 2'b00;
      ticks(1);
      item = 2'b10; change = 2'b01;
      tick();
      item = 2'b00; change = 2'b00;
      ticks(2);
      item_ready = 1'b1; coin_ready = 1'b1;
      ticks(20);

      // reset during COIN with two coins outstanding
      item = 2'b00; change = 2'b10;
      tick();
      change = 2'b00;
      tick();
      chk("s5.coin_valid_pre", {7'd0, cv0}, 8'd1);
      coin_ready = 1'b0;
      do_reset();
      chk("s5.busy", {7'd0, b0}, 8'd0);
      chk("s5.drop_err", {7'd0, de0}, 8'd0);
      ticks(3);

      // random traffic, occasional resets, then a long reset-free stretch for wrap
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            item   = 2'($urandom_range(0, 3));
            change = 2'($urandom_range(0, 3));
         end else begin
            item = 2'b00; change = 2'b00;
         end
         item_ready = ($urandom_range(0, 3) != 0);
         coin_ready = ($urandom_range(0, 3) != 0);
         if (i < 600 && $urandom_range(0, 149) == 0) do_reset();
         else tick();
      end
      item = 2'b00; change = 2'b00;
      ticks(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
